key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 105 ++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Per-channel key conditioner: two-flop synchronizer, bounce-rejecting level filter,
// press/release edge pulses and a single-shot long-press (hold) event.
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_pressed,
  output logic [NUM_KEYS-1:0] o_released,
  output logic [NUM_KEYS-1:0] o_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic          sync1_r;
    logic          sync2_r;
    logic          sample_s;
    logic [DW-1:0] deb_cnt_r;
    logic [DW-1:0] deb_cnt_s;
    logic          level_r;
    logic          level_s;
    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] hold_cnt_s;
    logic          fired_r;
    logic          fired_s;
    logic          held_s;
    logic          pressed_r;
    logic          released_r;
    logic          held_r;

    // Raw key is active-low; any disagreement with the accepted level must persist
    assign sample_s = ~sync2_r;

    // Next-state for the debounce filter and the long-press timer
    always_comb begin
      deb_cnt_s  = deb_cnt_r;
      level_s    = level_r;
      hold_cnt_s = hold_cnt_r;
      fired_s    = fired_r;
      held_s     = 1'b0;

      if (sample_s == level_r) begin
        deb_cnt_s = {DW{1'b0}};
      end else if (deb_cnt_r == DEB_MAX) begin
        level_s   = sample_s;
        deb_cnt_s = {DW{1'b0}};
      end else begin
        deb_cnt_s = deb_cnt_r + DW'(1);
      end

      // Timer freezes after firing so a long press yields exactly one event
      if (!level_r) begin
        hold_cnt_s = {HW{1'b0}};
        fired_s    = 1'b0;
      end else if (fired_r) begin
        hold_cnt_s = hold_cnt_r;
        fired_s    = 1'b1;
      end else if (hold_cnt_r == HOLD_MAX) begin
        held_s     = 1'b1;
        fired_s    = 1'b1;
      end else begin
        hold_cnt_s = hold_cnt_r + HW'(1);
      end
    end

    // State and registered event pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync1_r    <= 1'b1;
        sync2_r    <= 1'b1;
        deb_cnt_r  <= {DW{1'b0}};
        level_r    <= 1'b0;
        hold_cnt_r <= {HW{1'b0}};
        fired_r    <= 1'b0;
        pressed_r  <= 1'b0;
        released_r <= 1'b0;
        held_r     <= 1'b0;
      end else begin
        sync1_r    <= i_key[g];
        sync2_r    <= sync1_r;
        deb_cnt_r  <= deb_cnt_s;
        level_r    <= level_s;
        hold_cnt_r <= hold_cnt_s;
        fired_r    <= fired_s;
        pressed_r  <= level_s & ~level_r;
        released_r <= ~level_s & level_r;
        held_r     <= held_s;
      end
    end

    assign o_level[g]    = level_r;
    assign o_pressed[g]  = pressed_r;
    assign o_released[g] = released_r;
    assign o_held[g]     = held_r;
  end

endmodule
